// File: rtl/rx_frame_writer_if.sv
// MAC receive stream and RX buffer write port seen by rx_frame_writer.
`ifndef BF
`define BF 8
`endif

interface rx_frame_writer_if;
  logic [63:0]  rx_data;
  logic [7:0]   rx_data_valid;
  logic         rx_good_frame;
  logic         rx_bad_frame;
  logic         wr_en;
  logic [`BF:0] wr_addr;
  logic [63:0]  wr_data;

  modport master (output rx_data, rx_data_valid, rx_good_frame, rx_bad_frame,
                  input  wr_en, wr_addr, wr_data);
  modport slave  (input  rx_data, rx_data_valid, rx_good_frame, rx_bad_frame,
                  output wr_en, wr_addr, wr_data);
endinterface

// File: rtl/rx_frame_writer.sv
// Writes MAC frames into the RX buffer as a length header plus payload qwords,
// committing good frames and rolling back bad or overflowing ones.
`ifndef BF
`define BF 8
`endif

module rx_frame_writer (
  input  logic             clk156,
  input  logic             reset_n,
  rx_frame_writer_if.slave bus,
  input  logic [`BF+1:0]   commited_rd_address,
  output logic [`BF+1:0]   commited_wr_address,
  output logic [31:0]      dropped_frames
);
  localparam int PW = `BF + 2;
  localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] CAP = {1'b0, {(PW-1){1'b1}}};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RECV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] DROP   = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] cur;
  logic [PW-1:0] rd_p0;
  logic [15:0]   len;
  logic [PW-1:0] start_ptr;
  logic [PW-1:0] land;
  logic [3:0]    beat_bytes;
  logic          beat;
  logic          fit;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Occupancy after a write at 'at' (header slot included) must stay within D-1.
  function automatic logic fits(input logic [PW-1:0] at, input logic [PW-1:0] rd);
    logic [PW-1:0] fill;
    fill = at + ONE - rd;
    return fill <= CAP;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // A frame starting in the COMMIT cycle begins at the pointer being committed.
  always_comb begin
    beat       = |bus.rx_data_valid;
    beat_bytes = popcount8(bus.rx_data_valid);
    start_ptr  = (state == COMMIT) ? cur : commited_wr_address;
    land       = (state == RECV) ? cur : start_ptr + ONE;
    fit        = fits(land, rd_p0);
  end

  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      cur                 <= '0;
      rd_p0               <= '0;
      len                 <= '0;
      bus.wr_en           <= 1'b0;
      bus.wr_addr         <= '0;
      bus.wr_data         <= '0;
      commited_wr_address <= '0;
      dropped_frames      <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      rd_p0     <= commited_rd_address;
      case (state)
        IDLE, COMMIT: begin
          if (state == COMMIT) commited_wr_address <= cur;
          if (beat) begin
            len <= {12'h000, beat_bytes};
            if (fit) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= land[`BF:0];
              bus.wr_data <= bus.rx_data;
              cur         <= land + ONE;
              state       <= RECV;
            end else begin
              state <= DROP;
            end
          end else begin
            state <= IDLE;
          end
        end
        RECV: begin
          if (bus.rx_good_frame) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= commited_wr_address[`BF:0];
            bus.wr_data <= {48'h0, len};
            state       <= COMMIT;
          end else if (bus.rx_bad_frame) begin
            cur   <= commited_wr_address;
            state <= IDLE;
          end else if (beat) begin
            if (fit) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= cur[`BF:0];
              bus.wr_data <= bus.rx_data;
              cur         <= cur + ONE;
              len         <= len + {12'h000, beat_bytes};
            end else begin
              state <= DROP;
            end
          end
        end
        default: begin
          if (bus.rx_good_frame || bus.rx_bad_frame) begin
            cur            <= commited_wr_address;
            dropped_frames <= sat_inc(dropped_frames);
            state          <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/rx_frame_writer.md
# rx_frame_writer

Receive-side front end in the clk156 domain. It takes Ethernet frames from the 10G MAC client interface and writes them as 64-bit qwords into the internal RX buffer. Each frame is preceded by a length-header qword. The block publishes `commited_wr_address`, which `tlp_trigger` consumes to schedule TLPs toward the host huge pages. Bad frames and frames that do not fit the free space are rolled back and never committed.

## Interface
- No parameters. Widths come from the `` `BF`` define (includes.v).
  - Buffer depth D = 2^(`BF`+1) qwords.
  - Usable capacity is D-1 qwords.
  - Pointers are [`BF`+1:0]: [`BF`:0] is the RAM address; the MSB is the wrap bit.
- clk156  in  1  156.25 MHz clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  64  MAC receive data; byte 0 = bits [7:0].
- rx_data_valid  in  8  per-byte valid.
  - 8'hFF on all beats except the last.
  - The last beat is contiguous from bit 0.
  - 8'h00 means idle.
- rx_good_frame  in  1  one-cycle pulse; end of a good frame; only with rx_data_valid=0.
- rx_bad_frame  in  1  one-cycle pulse; end of a bad frame; only with rx_data_valid=0.
- commited_rd_address  in  [`BF`+1:0]  read pointer from the 250 MHz domain; registered once on entry.
- wr_en  out  1  RX buffer write strobe.
- wr_addr  out  [`BF`:0]  RX buffer write address.
- wr_data  out  64  RX buffer write data.
- commited_wr_address  out  [`BF`+1:0]  pointer one past the last fully written committed frame.
- dropped_frames  out  32  overflow-drop counter; saturates at 32'hFFFFFFFF.

## Operation
- **Frame layout** at start pointer S:
  - Header at S: [15:0] = byte count, [63:16] = 0.
  - Payload at S+1 … S+ceil(len/8).
  - Footprint = 1 + ceil(len/8) qwords. No padding.
  - All arithmetic is modulo D for addresses and modulo 2D for pointers.
- **Internal state:**
  - `cur` = next payload pointer.
  - `len` = 16-bit byte count; adds popcount(rx_data_valid) per beat.
  - `rd_reg` = registered commited_rd_address.
- **Space check** on every beat, with the write landing at `cur`: it fits if (`cur` + 1 − `rd_reg`) mod 2D ≤ D−1.
- **FSM states:** IDLE, RECV, COMMIT, DROP.
  - **IDLE:**
    - On rx_data_valid≠0: S = `cur_base` = commited_wr_address. Beat goes to S+1, `cur` = S+2, `len` = popcount.
    - If that beat fails the space check → DROP (no write). Otherwise → RECV.
    - A good or bad pulse in IDLE is ignored.
  - **RECV:**
    - On rx_data_valid≠0 and the space check passes: write the beat, `cur`++, `len` += popcount.
    - On rx_data_valid≠0 and the space check fails → DROP. Already-written qwords are abandoned.
    - On rx_data_valid=0: hold.
    - On rx_good_frame → COMMIT.
    - On rx_bad_frame → IDLE. No commit; `cur` rewinds to commited_wr_address.
  - **COMMIT** (one cycle):
    - Issue the header write at S with `len`.
    - The new commited_wr_address = `cur`.
    - A first beat of the next frame arriving in this cycle is accepted exactly as in IDLE, with S = the new end pointer (`cur`) → RECV/DROP.
    - Otherwise → IDLE.
  - **DROP:**
    - No writes.
    - On good or bad pulse: `cur` rewinds to commited_wr_address, → IDLE.
    - dropped_frames increments on that pulse, whether good or bad.
- Header and payload writes never collide: there is a single write port, and the header cycle has no payload write.
- A zero-byte good frame (pulse with no beats) cannot occur, because a frame starts only on data.

## Timing
- **Reset values:**
  - wr_en=0, wr_addr=0, wr_data=0.
  - commited_wr_address=0, dropped_frames=0.
  - FSM in IDLE, `cur`=0, `len`=0, `rd_reg`=0.
- **Payload write latency:** a beat sampled at cycle t produces wr_en/wr_addr/wr_data at t+1. All outputs are registered.
- **Good-frame completion:**
  - rx_good_frame sampled at t → header write at t+1.
  - commited_wr_address updates at t+2, after the header is in RAM.
  - The next frame's first beat sampled at t+1 writes at t+2.
- **Space-check pessimism:** it uses `rd_reg`, which is one cycle stale. The check errs toward dropping, never toward overwriting.
- **Reset mid-frame:** all state clears asynchronously. The partial frame is lost and not counted.

## Test plan
Directed scenarios use `BF`=8, so D=512 and capacity is 511 qwords.
1. **Basic good frame.** Reset, rd=0. Send a 64-byte frame (8 beats of 8'hFF), then a good pulse at t.
   - Writes go to addr 1..8.
   - Header write at addr 0 with data 64'h40 at t+1.
   - commited_wr_address becomes 9 at t+2.
2. **Partial last beat.** Send a 61-byte frame whose last beat is 8'h1F.
   - Header = 64'h3D.
   - Footprint is 9 qwords; the commit advances by 9.
3. **Bad-frame rollback.** After scenario 1, send a 32-byte frame ending in rx_bad_frame.
   - commited_wr_address stays 9.
   - The next good 16-byte frame writes its header at 9 and payload at 10..11; the commit becomes 12.
4. **Overflow drop and recovery.** Hold rd=0 with committed=500, then send a 128-byte frame.
   - Footprint 17 exceeds the 11 free qwords: no write beyond addr 510, dropped_frames=1, commit stays 500.
   - Set rd=100 and resend: the frame commits at 517.
5. **Wrap-around.** With rd = wr = 508, send a 64-byte frame.
   - Header at addr 508; payload at 509..511, 0..4.
   - commited_wr_address = 517; the wrap bit toggles.
6. **Back-to-back frames and reset mid-frame.** Send a first beat of frame B in the cycle after frame A's good pulse.
   - Header of A and payload of B are written in distinct cycles; both commit correctly.
   - Assert reset_n=0 mid-frame: all outputs return to their reset values immediately.
